pc_hazard_ctrl: RTL and testbench
=================================

# pc_hazard_ctrl

Pipeline sequencing controller for the fetch stage. It decides each cycle whether the PC register advances, holds, or redirects to a branch or jump target. It drives the PC write enable and the two target-select lines into the PC register block. It also drives the IF/ID write enable and flush, the ID/EX bubble insert, saturating stall/flush performance counters and a sticky data-memory timeout flag.

## Interface
- TIMEOUT, 64: dmem_busy cycles before mem_timeout sets (range 2..65535).
- CNT_W, 16: width of the performance counters.
- clk  in  1  clock; every state element updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction reads rs1 / rs2.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_branch  in  1  the instruction in EX is a beq.
- ex_eq  in  1  the beq compare result in EX.
- ex_jump  in  1  the instruction in EX is a jump.
- imem_ready  in  1  instruction memory returns a valid word this cycle.
- dmem_busy  in  1  data memory is not complete; the whole pipeline must freeze.
- pc_write  out  1  PC register write enable.
- beq_pc_sel  out  1  select the branch target.
- jump_pc_sel  out  1  select the jump target.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- state  out  2  FSM state: RUN=0, LU_STALL=1, MEM_WAIT=2, FETCH_WAIT=3.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.
- mem_timeout  out  1  sticky timeout flag.

## Operation
- The control outputs (pc_write, the two selects, if_id_write, if_id_flush, id_ex_bubble) are combinational from the registered state and the current inputs.
- state, the counters, the internal wait counter and mem_timeout are registered.
- Evaluate these conditions in priority order each cycle:
  1. dmem_busy=1: pc_write=0, if_id_write=0, all selects, flush and bubble 0. Next state MEM_WAIT.
  2. Redirect, defined as (ex_branch & ex_eq) | ex_jump: pc_write=1, if_id_flush=1, id_ex_bubble=1. beq_pc_sel = ex_branch & ex_eq. jump_pc_sel = ex_jump & ~beq_pc_sel, so branch wins if both are set. Next state RUN.
  3. Load-use hazard, defined as ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)): pc_write=0, if_id_write=0, id_ex_bubble=1. Next state LU_STALL.
  4. imem_ready=0: pc_write=0, if_id_write=0, id_ex_bubble=0. Next state FETCH_WAIT.
  5. Otherwise: pc_write=1, if_id_write=1, both selects 0. Next state RUN.
- The same priority applies from every state.
  - LU_STALL lasts exactly one cycle. The bubble means the hazard is not re-detected.
  - MEM_WAIT exits only when dmem_busy falls.
  - FETCH_WAIT exits when imem_ready rises or a redirect occurs.
- A redirect never waits for imem_ready; the in-flight fetch is discarded via if_id_flush.
- Counters:
  - stall_cnt increments once per cycle in which priority 1, 3 or 4 fires.
  - flush_cnt increments once per redirect cycle.
  - Both saturate at all-ones and never wrap.
- Wait counter:
  - Increments on each consecutive dmem_busy cycle and clears when dmem_busy=0.
  - On the cycle where it reaches TIMEOUT-1 while dmem_busy=1, mem_timeout sets on the next edge and stays set until reset.

## Timing
- Reset values: state=RUN, stall_cnt=0, flush_cnt=0, wait counter=0, mem_timeout=0.
- During a reset cycle the control outputs are forced to pc_write=0, if_id_write=0, and all selects, flush and bubble 0.
- Reset asserted mid-stall or mid-wait returns to RUN on the next edge, regardless of the inputs.
- Redirect latency: the PC holds the target one edge after ex_branch&ex_eq or ex_jump is sampled.
- Load-use stall costs exactly one cycle.
- A stall or flush event updates its counter on the edge that ends the event cycle.
- When dmem_busy and a redirect coincide, the redirect is deferred. EX is frozen, so it fires in the first cycle after dmem_busy falls.

## Test plan
- Reset, then a stream with imem_ready=1 and no hazards → pc_write=1 every cycle, counters stay 0, state=RUN.
- EX load with ex_rd=5, ID id_rs2=5, id_use_rs2=1 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. The next cycle is RUN with pc_write=1. stall_cnt=1.
- Same load but ex_rd=0 → no stall.
- ex_branch=1, ex_eq=1, ex_jump=1 with imem_ready=0 → beq_pc_sel=1, jump_pc_sel=0, pc_write=1, if_id_flush=1, flush_cnt=1.
- dmem_busy=1 for 3 cycles while ex_jump=1 → 3 frozen cycles (stall_cnt=3), then the jump redirect fires on cycle 4, mem_timeout=0.
- With TIMEOUT=4, hold dmem_busy for 6 cycles → mem_timeout rises after the 4th busy cycle and stays 1 after dmem_busy drops. It clears only on reset.
- Force stall_cnt to saturation (CNT_W=16, run 65540 stall cycles) → it holds at 65535.

Source files
------------

// File: rtl/pc_hazard_ctrl.sv
//==============================================================================
// Module   : pc_hazard_ctrl
// Brief    : Fetch-stage sequencing: PC advance/hold/redirect, pipeline
//            stall/flush controls, stall/flush counters, dmem timeout flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch,
  input  logic             ex_eq,
  input  logic             ex_jump,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             beq_pc_sel,
  output logic             jump_pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int          c_WAIT_W  = 16;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LIM = c_WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LU_STALL   = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FETCH_WAIT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_timeout;

  logic w_beq_take;
  logic w_redirect;
  logic w_load_use;
  logic w_stall_evt;
  logic w_flush_evt;

  assign w_beq_take = ex_branch & ex_eq;
  assign w_redirect = w_beq_take | ex_jump;
  assign w_load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));

  // A frozen pipeline outranks everything; a redirect outranks fetch/hazard stalls.
  assign w_stall_evt = dmem_busy | (~w_redirect & (w_load_use | ~imem_ready));
  assign w_flush_evt = ~dmem_busy & w_redirect;

  always_comb begin
    pc_write     = 1'b0;
    beq_pc_sel   = 1'b0;
    jump_pc_sel  = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    w_next       = ST_RUN;
    if (reset) begin
      w_next = ST_RUN;
    end else if (dmem_busy) begin
      w_next = ST_MEM_WAIT;
    end else if (w_redirect) begin
      pc_write     = 1'b1;
      beq_pc_sel   = w_beq_take;
      jump_pc_sel  = ex_jump & ~w_beq_take;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      w_next       = ST_RUN;
    end else if (w_load_use) begin
      id_ex_bubble = 1'b1;
      w_next       = ST_LU_STALL;
    end else if (!imem_ready) begin
      w_next = ST_FETCH_WAIT;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      w_next      = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_stall_evt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
      // Wait counter parks at the limit so a long busy period cannot wrap it.
      if (!dmem_busy)
        r_wait <= '0;
      else if (r_wait != c_WAIT_LIM)
        r_wait <= r_wait + 1'b1;
      if (dmem_busy && (r_wait == c_WAIT_LIM))
        r_timeout <= 1'b1;
    end
  end

  assign state       = r_state;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;
  assign mem_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pc_hazard_ctrl.sv
//==============================================================================
// Module   : tb_pc_hazard_ctrl
// Brief    : Directed vector table plus hand sequences for pc_hazard_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read;
  logic             ex_branch, ex_eq, ex_jump, imem_ready, dmem_busy;
  logic             pc_write, beq_pc_sel, jump_pc_sel;
  logic             if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout;

  int total = 0;
  int bad   = 0;

  pc_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch(ex_branch), .ex_eq(ex_eq), .ex_jump(ex_jump),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .beq_pc_sel(beq_pc_sel), .jump_pc_sel(jump_pc_sel),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // ctl bit order: {pc_write, beq_pc_sel, jump_pc_sel, if_id_write, if_id_flush, id_ex_bubble}
  typedef struct {
    logic       busy, ready, br, eq, jmp, mrd;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [5:0] ctl, msk;
    logic [1:0] st;
    int         stall, flush;
  } vec_t;

  localparam logic [5:0] M_ALL = 6'b111111;
  localparam logic [5:0] M_RED = 6'b111011;

  vec_t tbl[18];

  function automatic logic [5:0] ctl_now();
    return {pc_write, beq_pc_sel, jump_pc_sel, if_id_write, if_id_flush, id_ex_bubble};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic busy, ready, br, eq, jmp, mrd,
                       input logic [4:0] rd, rs1, rs2, input logic u1, u2);
    dmem_busy = busy; imem_ready = ready; ex_branch = br; ex_eq = eq;
    ex_jump = jmp; ex_mem_read = mrd; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  task automatic idle();
    drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); step(); reset = 1'b0;
  endtask

  initial begin
    //            busy rdy br eq jmp mrd rd     rs1    rs2    u1 u2  ctl        msk    st    stall flush
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b1,1'b1,6'b100100,M_ALL,2'd0,0,0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd3, 5'd3, 5'd3, 1'b1,1'b1,6'b100100,M_ALL,2'd0,0,0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd5, 5'd1, 5'd5, 1'b0,1'b1,6'b000001,M_ALL,2'd1,1,0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd5, 5'd1, 5'd5, 1'b0,1'b1,6'b100100,M_ALL,2'd0,1,0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b1,1'b1,6'b100100,M_ALL,2'd0,1,0};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd7, 5'd7, 5'd2, 1'b0,1'b1,6'b100100,M_ALL,2'd0,1,0};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,5'd9, 5'd9, 5'd2, 1'b1,1'b0,6'b000001,M_ALL,2'd1,2,0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b110011,M_RED,2'd0,2,1};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b101011,M_RED,2'd0,2,2};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b100100,M_ALL,2'd0,2,2};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b000000,M_ALL,2'd3,3,2};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b000000,M_ALL,2'd3,4,2};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b100100,M_ALL,2'd0,4,2};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd4, 5'd4, 5'd2, 1'b1,1'b0,6'b000001,M_ALL,2'd1,5,2};
    tbl[14] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,5'd4, 5'd4, 5'd2, 1'b1,1'b0,6'b000000,M_ALL,2'd2,6,2};
    tbl[15] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b110011,M_RED,2'd0,6,3};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b100100,M_ALL,2'd0,6,3};
    tbl[17] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,6'b101011,M_RED,2'd0,6,4};

    // Reset with a live redirect on the inputs: controls must stay quiet.
    reset = 1'b1;
    drive(0, 1, 1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    #4;
    chk("rst_ctl", ctl_now(), 6'b000000);
    step();
    step();
    chk("rst_state", state, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_timeout", mem_timeout, 0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].busy, tbl[i].ready, tbl[i].br, tbl[i].eq, tbl[i].jmp, tbl[i].mrd,
            tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2);
      #3;
      chk($sformatf("v%0d_ctl", i), ctl_now() & tbl[i].msk, tbl[i].ctl & tbl[i].msk);
      step();
      chk($sformatf("v%0d_state", i), state, tbl[i].st);
      chk($sformatf("v%0d_stall", i), stall_cnt, tbl[i].stall);
      chk($sformatf("v%0d_flush", i), flush_cnt, tbl[i].flush);
    end
    chk("tbl_timeout", mem_timeout, 0);

    // Reset from FETCH_WAIT returns to RUN even with imem_ready low.
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    step();
    chk("fw_state", state, 3);
    reset = 1'b1;
    step();
    chk("fw_rst_state", state, 0);
    reset = 1'b0;

    // dmem_busy freezes a pending jump for three cycles, then it fires.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
      #3;
      chk($sformatf("frz%0d_ctl", c), ctl_now(), 6'b000000);
      step();
      chk($sformatf("frz%0d_state", c), state, 2);
    end
    drive(0, 1, 0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    #3;
    chk("frz_jump_ctl", ctl_now() & M_RED, 6'b101011);
    step();
    chk("frz_stall", stall_cnt, 3);
    chk("frz_flush", flush_cnt, 1);
    chk("frz_state", state, 0);
    chk("frz_timeout", mem_timeout, 0);

    // Timeout: flag rises on the edge ending the 4th busy cycle and is sticky.
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
      step();
      chk($sformatf("to_busy%0d", c), mem_timeout, (c >= TIMEOUT) ? 1 : 0);
    end
    idle();
    step();
    step();
    chk("to_sticky", mem_timeout, 1);
    do_reset();
    chk("to_cleared", mem_timeout, 0);

    // Saturation of stall_cnt through a long fetch stall.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    for (int c = 0; c < 65534; c++) step();
    chk("sat_before", stall_cnt, 65534);
    for (int c = 0; c < 6; c++) step();
    chk("sat_hold", stall_cnt, 65535);
    chk("sat_flush", flush_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
